// File: rtl/fifo_pkg.sv
// ============================================================================
// Module   : fifo_pkg
// Brief    : Shared helpers for the async FIFO pointer controllers.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fifo_pkg;

    // Pointers are zero-extended into this width, so the helpers work for any pointer up to 32 bits.
    localparam int GRAY_MAX_W = 32;

    typedef logic [GRAY_MAX_W-1:0] gvec_t;

    function automatic gvec_t bin2gray(input gvec_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic gvec_t gray2bin(input gvec_t g);
        gvec_t b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cdc_sync_bus.sv
// ============================================================================
// Module   : cdc_sync_bus
// Brief    : Async-reset multi-flop synchronizer for a Gray-coded bus.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cdc_sync_bus #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/wptr_full_ctrl.sv
// ============================================================================
// Module   : wptr_full_ctrl
// Brief    : Write-side pointer, full/almost-full, level and overflow status.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wptr_full_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH   = 9,
    parameter int AFULL_THRESH = 480,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                  w_clk,
    input  logic                  wrst,
    input  logic                  w_en,
    input  logic                  ovf_clr,
    input  logic [ADDR_WIDTH:0]   rptr_gray_async,
    output logic                  w_inc,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr_gray,
    output logic                  wfull,
    output logic                  walmost_full,
    output logic [ADDR_WIDTH:0]   wlevel,
    output logic                  woverflow
);

    localparam int A = ADDR_WIDTH;

    typedef logic [A:0] ptr_t;

    localparam ptr_t THRESH = ptr_t'(AFULL_THRESH);

    ptr_t wbin;
    ptr_t wbin_n;
    ptr_t wgray_n;
    ptr_t rq;
    ptr_t rbin;
    ptr_t full_cmp;
    ptr_t level_n;

    cdc_sync_bus #(
        .WIDTH  (A + 1),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .clk   (w_clk),
        .rst_n (wrst),
        .d     (rptr_gray_async),
        .q     (rq)
    );

    assign w_inc   = w_en & ~wfull;
    assign wbin_n  = wbin + ptr_t'(w_inc);
    assign wgray_n = ptr_t'(bin2gray(gvec_t'(wbin_n)));
    assign rbin    = ptr_t'(gray2bin(gvec_t'(rq)));

    // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
    assign full_cmp = {~rq[A:A-1], rq[A-2:0]};
    assign level_n  = wbin_n - rbin;

    assign waddr = wbin[A-1:0];

    always_ff @(posedge w_clk or negedge wrst) begin
        if (!wrst) begin
            wbin         <= '0;
            wptr_gray    <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wlevel       <= '0;
            woverflow    <= 1'b0;
        end else begin
            wbin         <= wbin_n;
            wptr_gray    <= wgray_n;
            wfull        <= (wgray_n == full_cmp);
            walmost_full <= (level_n >= THRESH);
            wlevel       <= level_n;
            // Set has priority over clear so a coincident overflow is never lost.
            if (w_en && wfull) begin
                woverflow <= 1'b1;
            end else if (ovf_clr) begin
                woverflow <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wptr_full_ctrl.sv
// ============================================================================
// Module   : tb_wptr_full_ctrl
// Brief    : Directed self-checking bench for wptr_full_ctrl (ADDR_WIDTH=4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wptr_full_ctrl;

    localparam int AW = 4;

    logic          w_clk;
    logic          wrst;
    logic          w_en;
    logic          ovf_clr;
    logic [AW:0]   rptr_gray_async;
    logic          w_inc;
    logic [AW-1:0] waddr;
    logic [AW:0]   wptr_gray;
    logic          wfull;
    logic          walmost_full;
    logic [AW:0]   wlevel;
    logic          woverflow;

    int passed;
    int total;

    wptr_full_ctrl #(
        .ADDR_WIDTH   (AW),
        .AFULL_THRESH (12),
        .SYNC_STAGES  (2)
    ) dut (
        .w_clk           (w_clk),
        .wrst            (wrst),
        .w_en            (w_en),
        .ovf_clr         (ovf_clr),
        .rptr_gray_async (rptr_gray_async),
        .w_inc           (w_inc),
        .waddr           (waddr),
        .wptr_gray       (wptr_gray),
        .wfull           (wfull),
        .walmost_full    (walmost_full),
        .wlevel          (wlevel),
        .woverflow       (woverflow)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    function automatic logic [AW:0] gray(input int v);
        logic [AW:0] b;
        b = v[AW:0];
        return b ^ (b >> 1);
    endfunction

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    task automatic do_reset();
        wrst            = 1'b0;
        w_en            = 1'b0;
        ovf_clr         = 1'b0;
        rptr_gray_async = '0;
        repeat (2) @(posedge w_clk);
        #1;
        wrst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        total++;
        if ({wptr_gray, waddr, wfull, walmost_full, wlevel, woverflow, w_inc} !== '0)
            $display("FAIL reset_idle: got gray=%b addr=%0d full=%b af=%b lvl=%0d ovf=%b inc=%b, want all 0",
                     wptr_gray, waddr, wfull, walmost_full, wlevel, woverflow, w_inc);
        else passed++;
        w_en = 1'b1;
        repeat (3) tick();
        total++;
        if (wlevel !== 5'd3 || waddr !== 4'd3)
            $display("FAIL reset_preburst: got lvl=%0d addr=%0d, want 3/3", wlevel, waddr);
        else passed++;
        #2 wrst = 1'b0;
        #1;
        total++;
        if (wlevel !== 5'd0 || wptr_gray !== 5'd0 || waddr !== 4'd0)
            $display("FAIL reset_async: got lvl=%0d gray=%b addr=%0d, want 0", wlevel, wptr_gray, waddr);
        else passed++;
    endtask

    task automatic test_fill();
        do_reset();
        w_en = 1'b1;
        repeat (15) tick();
        total++;
        if (wfull !== 1'b0 || wlevel !== 5'd15)
            $display("FAIL fill_15: got full=%b lvl=%0d, want 0/15", wfull, wlevel);
        else passed++;
        tick();
        total++;
        if (wptr_gray !== 5'b11000 || wlevel !== 5'd16 || wfull !== 1'b1 || waddr !== 4'd0)
            $display("FAIL fill_16: got gray=%b lvl=%0d full=%b addr=%0d, want 11000/16/1/0",
                     wptr_gray, wlevel, wfull, waddr);
        else passed++;
        total++;
        if (w_inc !== 1'b0)
            $display("FAIL fill_inc_blocked: got w_inc=%b, want 0", w_inc);
        else passed++;
        tick();
        total++;
        if (wptr_gray !== 5'b11000 || wlevel !== 5'd16 || waddr !== 4'd0)
            $display("FAIL fill_17_hold: got gray=%b lvl=%0d addr=%0d, want 11000/16/0",
                     wptr_gray, wlevel, waddr);
        else passed++;
    endtask

    // Continues from the full state left by test_fill.
    task automatic test_overflow();
        total++;
        if (woverflow !== 1'b1)
            $display("FAIL ovf_set: got %b, want 1", woverflow);
        else passed++;
        w_en = 1'b0;
        tick();
        total++;
        if (woverflow !== 1'b1)
            $display("FAIL ovf_sticky: got %b, want 1", woverflow);
        else passed++;
        w_en    = 1'b1;
        ovf_clr = 1'b1;
        tick();
        total++;
        if (woverflow !== 1'b1)
            $display("FAIL ovf_set_wins: got %b, want 1", woverflow);
        else passed++;
        w_en = 1'b0;
        tick();
        total++;
        if (woverflow !== 1'b0)
            $display("FAIL ovf_clear: got %b, want 0", woverflow);
        else passed++;
        ovf_clr = 1'b0;
    endtask

    task automatic test_almost_full();
        do_reset();
        w_en = 1'b1;
        repeat (11) tick();
        total++;
        if (walmost_full !== 1'b0)
            $display("FAIL af_11: got %b, want 0", walmost_full);
        else passed++;
        tick();
        total++;
        if (walmost_full !== 1'b1 || wlevel !== 5'd12)
            $display("FAIL af_12: got af=%b lvl=%0d, want 1/12", walmost_full, wlevel);
        else passed++;
        w_en            = 1'b0;
        rptr_gray_async = 5'b00110;
        repeat (2) tick();
        total++;
        if (wlevel !== 5'd12 || walmost_full !== 1'b1)
            $display("FAIL af_sync_edge2: got lvl=%0d af=%b, want 12/1", wlevel, walmost_full);
        else passed++;
        tick();
        total++;
        if (wlevel !== 5'd8 || walmost_full !== 1'b0)
            $display("FAIL af_sync_edge3: got lvl=%0d af=%b, want 8/0", wlevel, walmost_full);
        else passed++;
    endtask

    task automatic test_wrap();
        int bad_lvl;
        int bad_full;
        bad_lvl  = 0;
        bad_full = 0;
        do_reset();
        w_en = 1'b1;
        for (int m = 1; m <= 40; m++) begin
            rptr_gray_async = gray(m % 32);
            tick();
            if (m >= 2 && wlevel !== 5'd2) bad_lvl++;
            if (wfull !== 1'b0) bad_full++;
            if (m == 32) begin
                total++;
                if (wptr_gray !== 5'd0 || waddr !== 4'd0)
                    $display("FAIL wrap_rollover: got gray=%b addr=%0d, want 0/0", wptr_gray, waddr);
                else passed++;
            end
        end
        total++;
        if (bad_lvl != 0)
            $display("FAIL wrap_level: %0d cycles with level != 2, want 0", bad_lvl);
        else passed++;
        total++;
        if (bad_full != 0)
            $display("FAIL wrap_full: %0d cycles with wfull=1, want 0", bad_full);
        else passed++;
        total++;
        if (wptr_gray !== 5'b01100 || waddr !== 4'd8)
            $display("FAIL wrap_end: got gray=%b addr=%0d, want 01100/8", wptr_gray, waddr);
        else passed++;
        w_en = 1'b0;
    endtask

    task automatic test_concurrent();
        do_reset();
        w_en = 1'b1;
        repeat (15) tick();
        w_en            = 1'b0;
        rptr_gray_async = gray(1);
        repeat (2) tick();
        total++;
        if (wlevel !== 5'd15)
            $display("FAIL conc_pre: got lvl=%0d, want 15", wlevel);
        else passed++;
        w_en = 1'b1;
        tick();
        total++;
        if (wlevel !== 5'd15 || wfull !== 1'b0 || wptr_gray !== 5'b11000)
            $display("FAIL conc_both: got lvl=%0d full=%b gray=%b, want 15/0/11000",
                     wlevel, wfull, wptr_gray);
        else passed++;
        w_en = 1'b0;
        tick();
        total++;
        if (wlevel !== 5'd15 || wfull !== 1'b0)
            $display("FAIL conc_after: got lvl=%0d full=%b, want 15/0", wlevel, wfull);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_fill();
        test_overflow();
        test_almost_full();
        test_wrap();
        test_concurrent();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
